// File: rtl/onchip_arb_pkg.sv
// Shared types and constants for the two-master on-chip RAM arbiter.
// Used by onchip_memory_arbiter and onchip_arb_rr_pick.
package onchip_arb_pkg;

  localparam int ONCHIP_ADDR_W = 10;
  localparam int ONCHIP_DATA_W = 32;
  localparam int ONCHIP_BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Mask with the low 'width' bits set, for driving full-word byteenables on reads.
  function automatic logic [31:0] be_all_ones(input int unsigned width);
    if (width >= 32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/onchip_arb_rr_pick.sv
// Combinational two-way grant pick: round-robin with a bounded owner hold,
// or plain master-0 priority when RR_EN is 0.
module onchip_arb_rr_pick
  import onchip_arb_pkg::*;
#(
  parameter bit RR_EN    = 1'b1,
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 4
) (
  input  logic              req0_i,
  input  logic              req1_i,
  input  arb_state_t        state_i,
  input  logic              rr_last_i,
  input  logic [HOLD_W-1:0] hold_cnt_i,
  output logic              gnt_idx_o,
  output logic              gnt_valid_o
);

  localparam logic [HOLD_W-1:0] HoldMax = HOLD_W'(MAX_HOLD);

  logic holdDone;

  assign holdDone = (hold_cnt_i >= HoldMax);

  always_comb begin
    gnt_valid_o = req0_i | req1_i;
    gnt_idx_o   = 1'b0;
    if (req0_i && req1_i) begin
      if (RR_EN) begin
        // Owner keeps the grant until its hold budget is spent; from IDLE the tie
        // goes to whoever did not win last.
        case (state_i)
          OWN0:    gnt_idx_o = holdDone;
          OWN1:    gnt_idx_o = ~holdDone;
          default: gnt_idx_o = ~rr_last_i;
        endcase
      end else begin
        gnt_idx_o = 1'b0;
      end
    end else begin
      gnt_idx_o = req1_i;
    end
  end

endmodule

// File: rtl/onchip_memory_arbiter.sv
// Shares one single-port 1024x32 RAM between two Avalon-MM masters.
// Define ONCHIP_ARB_RR_EN for round-robin with MAX_HOLD; default is master-0 priority.
module onchip_memory_arbiter
  import onchip_arb_pkg::*;
#(
  parameter int ADDR_W   = ONCHIP_ADDR_W,
  parameter int DATA_W   = ONCHIP_DATA_W,
  parameter int BE_W     = ONCHIP_BE_W,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,

  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam int HOLD_W = 4;
  localparam logic [31:0]     BeMaskFull = be_all_ones(BE_W);
  localparam logic [BE_W-1:0] BeMask     = BeMaskFull[BE_W-1:0];

  arb_state_t        state_q, state_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_src_q, rd_src_d;
  logic              rr_last_q;
  logic [HOLD_W-1:0] hold_q;

  logic              req0, req1;
  logic              gntIdx, gntValid, accept;
  logic              selRead, selWrite, readAccept;
  logic [ADDR_W-1:0] selAddr;
  logic [BE_W-1:0]   selBe;
  logic [DATA_W-1:0] selData;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  onchip_arb_rr_pick #(
`ifdef ONCHIP_ARB_RR_EN
    .RR_EN    (1'b1),
`else
    .RR_EN    (1'b0),
`endif
    .MAX_HOLD (MAX_HOLD),
    .HOLD_W   (HOLD_W)
  ) u_pick (
    .req0_i      (req0),
    .req1_i      (req1),
    .state_i     (state_q),
    .rr_last_i   (rr_last_q),
    .hold_cnt_i  (hold_q),
    .gnt_idx_o   (gntIdx),
    .gnt_valid_o (gntValid)
  );

  // Nothing is accepted while reset is high, so no RAM access or read tag leaks out.
  assign accept   = gntValid & ~reset;

  assign selRead  = gntIdx ? m1_read       : m0_read;
  assign selWrite = gntIdx ? m1_write      : m0_write;
  assign selAddr  = gntIdx ? m1_address    : m0_address;
  assign selBe    = gntIdx ? m1_byteenable : m0_byteenable;
  assign selData  = gntIdx ? m1_writedata  : m0_writedata;

  assign readAccept = accept & selRead & ~selWrite;

  assign mem_chipselect = accept;
  assign mem_write      = accept & selWrite;
  assign mem_address    = selAddr;
  assign mem_byteenable = selWrite ? selBe : BeMask;
  assign mem_writedata  = selData;
  assign mem_clken      = ~reset;

  assign m0_waitrequest = ~(accept & ~gntIdx);
  assign m1_waitrequest = ~(accept & gntIdx);

  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rd_pend_q & ~rd_src_q & ~reset;
  assign m1_readdatavalid = rd_pend_q & rd_src_q & ~reset;

  always_comb begin
    state_d   = IDLE;
    rd_pend_d = readAccept;
    rd_src_d  = rd_src_q;
    if (accept) begin
      state_d = gntIdx ? OWN1 : OWN0;
    end
    if (readAccept) begin
      rd_src_d = gntIdx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_pend_q <= 1'b0;
      rd_src_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_pend_d;
      rd_src_q  <= rd_src_d;
    end
  end

`ifdef ONCHIP_ARB_RR_EN
  logic              rr_last_d;
  logic [HOLD_W-1:0] hold_d;
  logic              otherReq, ownerKeeps;

  assign otherReq   = gntIdx ? req0 : req1;
  assign ownerKeeps = (state_q == OWN0 && !gntIdx) || (state_q == OWN1 && gntIdx);

  // The hold count includes the transfer that took ownership, so each owner gets
  // exactly MAX_HOLD contended transfers before handing over.
  always_comb begin
    rr_last_d = rr_last_q;
    hold_d    = '0;
    if (accept) begin
      rr_last_d = gntIdx;
      if (otherReq) begin
        if (!ownerKeeps) begin
          hold_d = HOLD_W'(1);
        end else if (hold_q < HOLD_W'(MAX_HOLD)) begin
          hold_d = hold_q + HOLD_W'(1);
        end else begin
          hold_d = hold_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last_q <= 1'b1;
      hold_q    <= '0;
    end else begin
      rr_last_q <= rr_last_d;
      hold_q    <= hold_d;
    end
  end
`else
  assign rr_last_q = 1'b1;
  assign hold_q    = '0;
`endif

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Directed self-checking bench for onchip_memory_arbiter with a behavioural RAM.
// Checks the round-robin sequence when ONCHIP_ARB_RR_EN is defined, fixed priority otherwise.
module tb_onchip_memory_arbiter;

  logic        clk;
  logic        reset;
  logic [9:0]  m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [9:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] ram [0:1023];

  onchip_memory_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with byte lanes and a registered read port.
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
        end
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic applyStimulus(input int m, input logic rd, input logic wr,
                               input logic [9:0] addr, input logic [3:0] be,
                               input logic [31:0] data);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = addr; m0_byteenable = be; m0_writedata = data;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = addr; m1_byteenable = be; m1_writedata = data;
    end
  endtask

  task automatic driveIdle();
    applyStimulus(0, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 10'd5, 4'hF, 32'h0);
    applyStimulus(1, 1'b0, 1'b1, 10'd6, 4'hF, 32'h1);
    @(negedge clk);
    checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL reset_m0_wait: got %b want 1", m0_waitrequest); end
    checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL reset_m1_wait: got %b want 1", m1_waitrequest); end
    checks++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rdv: got %b%b want 00", m0_readdatavalid, m1_readdatavalid); end
    checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("[TB] FAIL reset_cs: got %b want 0", mem_chipselect); end
    checks++; if (mem_clken !== 1'b0) begin errors++; $display("[TB] FAIL reset_clken: got %b want 0", mem_clken); end
    nextCycle();
    reset = 1'b0;
    driveIdle();
    @(negedge clk);
    checks++; if (mem_clken !== 1'b1) begin errors++; $display("[TB] FAIL idle_clken: got %b want 1", mem_clken); end
    checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("[TB] FAIL idle_cs: got %b want 0", mem_chipselect); end
    checks++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL idle_wait: got %b%b want 11", m0_waitrequest, m1_waitrequest); end
    nextCycle();
  endtask

  task automatic test_write_read();
    applyStimulus(0, 1'b0, 1'b1, 10'd5, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL wr_m0_wait: got %b want 0", m0_waitrequest); end
    checks++; if (mem_write !== 1'b1 || mem_chipselect !== 1'b1 || mem_address !== 10'd5) begin errors++; $display("[TB] FAIL wr_mem: got we=%b cs=%b a=%0d want 1 1 5", mem_write, mem_chipselect, mem_address); end
    checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("[TB] FAIL wr_m1_wait: got %b want 1", m1_waitrequest); end
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 10'd5, 4'h0, 32'h0);
    @(negedge clk);
    checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL rd_m0_wait: got %b want 0", m0_waitrequest); end
    checks++; if (mem_write !== 1'b0 || mem_byteenable !== 4'hF) begin errors++; $display("[TB] FAIL rd_mem: got we=%b be=%h want 0 f", mem_write, mem_byteenable); end
    checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL rd_early_rdv: got %b want 0", m0_readdatavalid); end
    nextCycle();
    driveIdle();
    @(negedge clk);
    checks++; if (m0_readdatavalid !== 1'b1) begin errors++; $display("[TB] FAIL rd_m0_rdv: got %b want 1", m0_readdatavalid); end
    checks++; if (m0_readdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rd_m0_data: got %h want deadbeef", m0_readdata); end
    checks++; if (m1_readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL rd_m1_quiet: got %b want 0", m1_readdatavalid); end
    nextCycle();
  endtask

  task automatic test_byte_lane();
    applyStimulus(0, 1'b0, 1'b1, 10'd9, 4'hF, 32'h11223344);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b1, 10'd9, 4'h1, 32'h000000AA);
    @(negedge clk);
    checks++; if (mem_byteenable !== 4'h1) begin errors++; $display("[TB] FAIL bl_wr_be: got %h want 1", mem_byteenable); end
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 10'd9, 4'h1, 32'h0);
    @(negedge clk);
    checks++; if (mem_byteenable !== 4'hF) begin errors++; $display("[TB] FAIL bl_rd_be: got %h want f", mem_byteenable); end
    nextCycle();
    driveIdle();
    @(negedge clk);
    checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h112233AA) begin errors++; $display("[TB] FAIL bl_data: got v=%b d=%h want 1 112233aa", m0_readdatavalid, m0_readdata); end
    nextCycle();
  endtask

  task automatic test_interleave();
    applyStimulus(0, 1'b0, 1'b1, 10'd3, 4'hF, 32'h33333333);
    nextCycle();
    driveIdle();
    applyStimulus(1, 1'b0, 1'b1, 10'd7, 4'hF, 32'h77777777);
    @(negedge clk);
    checks++; if (m1_waitrequest !== 1'b0 || mem_address !== 10'd7) begin errors++; $display("[TB] FAIL il_m1_wr: got w=%b a=%0d want 0 7", m1_waitrequest, mem_address); end
    nextCycle();
    driveIdle();
    applyStimulus(0, 1'b1, 1'b0, 10'd3, 4'h0, 32'h0);
    nextCycle();
    driveIdle();
    applyStimulus(1, 1'b1, 1'b0, 10'd7, 4'h0, 32'h0);
    @(negedge clk);
    checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h33333333) begin errors++; $display("[TB] FAIL il_m0_ret: got v=%b d=%h want 1 33333333", m0_readdatavalid, m0_readdata); end
    checks++; if (m1_readdatavalid !== 1'b0 || m1_waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL il_m1_t1: got v=%b w=%b want 0 0", m1_readdatavalid, m1_waitrequest); end
    nextCycle();
    driveIdle();
    @(negedge clk);
    checks++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h77777777) begin errors++; $display("[TB] FAIL il_m1_ret: got v=%b d=%h want 1 77777777", m1_readdatavalid, m1_readdata); end
    checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL il_m0_t2: got %b want 0", m0_readdatavalid); end
    nextCycle();
  endtask

  task automatic test_reset_mid_read();
    applyStimulus(0, 1'b1, 1'b0, 10'd3, 4'h0, 32'h0);
    @(negedge clk);
    checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL rr_acc_wait: got %b want 0", m0_waitrequest); end
    nextCycle();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL mid_rdv[%0d]: got %b want 0", i, m0_readdatavalid); end
      checks++; if (mem_chipselect !== 1'b0 || m0_waitrequest !== 1'b1 || mem_clken !== 1'b0) begin errors++; $display("[TB] FAIL mid_outs[%0d]: got cs=%b w=%b ck=%b want 0 1 0", i, mem_chipselect, m0_waitrequest, mem_clken); end
      nextCycle();
    end
    reset = 1'b0;
    driveIdle();
    @(negedge clk);
    checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL mid_after_rdv: got %b want 0", m0_readdatavalid); end
    nextCycle();
  endtask

  task automatic test_contention();
`ifdef ONCHIP_ARB_RR_EN
    int expGnt [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
`else
    int expGnt [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
    logic expW0;
    applyStimulus(0, 1'b1, 1'b0, 10'd3, 4'h0, 32'h0);
    applyStimulus(1, 1'b1, 1'b0, 10'd7, 4'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      expW0 = (expGnt[i] != 0);
      checks++; if (m0_waitrequest !== expW0 || m1_waitrequest !== ~expW0) begin errors++; $display("[TB] FAIL ct_gnt[%0d]: got w0=%b w1=%b want %b %b", i, m0_waitrequest, m1_waitrequest, expW0, ~expW0); end
      if (i > 0) begin
        checks++;
        if (m0_readdatavalid !== (expGnt[i-1] == 0) || m1_readdatavalid !== (expGnt[i-1] != 0) ||
            m0_readdata !== ((expGnt[i-1] == 0) ? 32'h33333333 : 32'h77777777)) begin
          errors++; $display("[TB] FAIL ct_ret[%0d]: got v0=%b v1=%b d=%h", i, m0_readdatavalid, m1_readdatavalid, m0_readdata);
        end
      end
      nextCycle();
    end
    applyStimulus(0, 1'b0, 1'b0, 10'd0, 4'h0, 32'h0);
    @(negedge clk);
    checks++; if (m1_waitrequest !== 1'b0 || mem_address !== 10'd7) begin errors++; $display("[TB] FAIL ct_drop: got w1=%b a=%0d want 0 7", m1_waitrequest, mem_address); end
    nextCycle();
    driveIdle();
    @(negedge clk);
    checks++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h77777777 || m0_readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL ct_drop_ret: got v1=%b d=%h v0=%b want 1 77777777 0", m1_readdatavalid, m1_readdata, m0_readdatavalid); end
    nextCycle();
  endtask

  task automatic test_write_wins();
    applyStimulus(1, 1'b1, 1'b1, 10'd11, 4'hF, 32'hCAFEF00D);
    @(negedge clk);
    checks++; if (mem_write !== 1'b1 || m1_waitrequest !== 1'b0) begin errors++; $display("[TB] FAIL ww_write: got we=%b w1=%b want 1 0", mem_write, m1_waitrequest); end
    nextCycle();
    applyStimulus(1, 1'b1, 1'b0, 10'd11, 4'h0, 32'h0);
    @(negedge clk);
    checks++; if (m1_readdatavalid !== 1'b0) begin errors++; $display("[TB] FAIL ww_no_tag: got %b want 0", m1_readdatavalid); end
    nextCycle();
    driveIdle();
    @(negedge clk);
    checks++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL ww_data: got v=%b d=%h want 1 cafef00d", m1_readdatavalid, m1_readdata); end
    nextCycle();
  endtask

  initial begin
    reset = 1'b1;
    driveIdle();
    nextCycle();
    nextCycle();
    test_reset();
    test_write_read();
    test_byte_lane();
    test_interleave();
    test_reset_mid_read();
    test_contention();
    test_write_wins();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
